// File: rtl/switch_debounce.sv
// Two-channel switch synchroniser and debouncer feeding the LED blink stage.
// Build option SWITCH_DEBOUNCE_TOGGLE_EN turns each output into a push-button latch.
module switch_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_enable,
    input  logic i_raw_sw_1,
    input  logic i_raw_sw_2,
    output logic o_switch_1,
    output logic o_switch_2,
    output logic o_press_1,
    output logic o_press_2
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [1:0] {StLo, StWaitHi, StHi, StWaitLo} state_e;

    logic [1:0] raw;
    logic [1:0] sw;
    logic [1:0] press;

    assign raw = {i_raw_sw_2, i_raw_sw_1};

    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic             sync1_q, sync2_q;
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             sw_q, sw_d;
        logic             press_q, press_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            sw_d    = sw_q;
            press_d = 1'b0;
            if (!i_enable) begin
                // Park on the accepted level so re-enabling always costs a full wait.
                state_d = (state_q == StHi || state_q == StWaitLo) ? StHi : StLo;
                cnt_d   = '0;
            end else begin
                unique case (state_q)
                    StLo: begin
                        if (sync2_q) begin
                            state_d = StWaitHi;
                            cnt_d   = CntOne;
                        end
                    end
                    StWaitHi: begin
                        if (!sync2_q) begin
                            state_d = StLo;
                            cnt_d   = '0;
                        end else if (cnt_q == CntMax) begin
                            state_d = StHi;
                            cnt_d   = '0;
                            press_d = 1'b1;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
                            sw_d    = ~sw_q;
`else
                            sw_d    = 1'b1;
`endif
                        end else begin
                            cnt_d = cnt_q + CntOne;
                        end
                    end
                    StHi: begin
                        if (!sync2_q) begin
                            state_d = StWaitLo;
                            cnt_d   = CntOne;
                        end
                    end
                    StWaitLo: begin
                        if (sync2_q) begin
                            state_d = StHi;
                            cnt_d   = '0;
                        end else if (cnt_q == CntMax) begin
                            state_d = StLo;
                            cnt_d   = '0;
`ifndef SWITCH_DEBOUNCE_TOGGLE_EN
                            sw_d    = 1'b0;
`endif
                        end else begin
                            cnt_d = cnt_q + CntOne;
                        end
                    end
                    default: begin
                        state_d = StLo;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                state_q <= StLo;
                cnt_q   <= '0;
                sw_q    <= 1'b0;
                press_q <= 1'b0;
            end else begin
                sync1_q <= raw[g];
                sync2_q <= sync1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                sw_q    <= sw_d;
                press_q <= press_d;
            end
        end

        assign sw[g]    = sw_q;
        assign press[g] = press_q;
    end

    assign o_switch_1 = sw[0];
    assign o_switch_2 = sw[1];
    assign o_press_1  = press[0];
    assign o_press_2  = press[1];

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=4 (accept 6 edges after first sample).
module tb_switch_debounce;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic raw1 = 1'b0;
    logic raw2 = 1'b0;
    logic sw1, sw2, pr1, pr2;

    int n_checks = 0;
    int n_fails = 0;
    int press1_cnt = 0;

    switch_debounce #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_enable  (en),
        .i_raw_sw_1(raw1),
        .i_raw_sw_2(raw2),
        .o_switch_1(sw1),
        .o_switch_2(sw2),
        .o_press_1 (pr1),
        .o_press_2 (pr2)
    );

    always #20 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (pr1 === 1'b1) press1_cnt++;
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        #5;
        check("reset_sw1", sw1, 1'b0);
        check("reset_sw2", sw2, 1'b0);
        check("reset_pr1", pr1, 1'b0);
        check("reset_pr2", pr2, 1'b0);
        tick(2);
        rst_n = 1'b1;

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
        raw1 = 1'b1;
        tick(6);
        check("tg_press1_early", sw1, 1'b0);
        tick(1);
        check("tg_press1_sw", sw1, 1'b1);
        check("tg_press1_pr", pr1, 1'b1);
        raw1 = 1'b0;
        tick(7);
        check("tg_rel1_sw", sw1, 1'b1);
        check("tg_rel1_pr", pr1, 1'b0);
        raw1 = 1'b1;
        tick(7);
        check("tg_press2_sw", sw1, 1'b0);
        check("tg_press2_pr", pr1, 1'b1);
        raw1 = 1'b0;
        tick(7);
        check("tg_rel2_sw", sw1, 1'b0);
        check("tg_rel2_pr", pr1, 1'b0);
        check("tg_sw2_idle", sw2, 1'b0);
        check("tg_press_count", (press1_cnt == 2), 1'b1);
`else
        // 1: clean press on channel 1
        raw1 = 1'b1;
        tick(6);
        check("t1_sw1_edge6", sw1, 1'b0);
        check("t1_pr1_edge6", pr1, 1'b0);
        tick(1);
        check("t1_sw1_edge7", sw1, 1'b1);
        check("t1_pr1_edge7", pr1, 1'b1);
        check("t1_sw2", sw2, 1'b0);
        check("t1_pr2", pr2, 1'b0);
        tick(1);
        check("t1_pr1_one_cycle", pr1, 1'b0);
        check("t1_sw1_hold", sw1, 1'b1);
        raw1 = 1'b0;
        tick(7);
        check("t1_release_sw1", sw1, 1'b0);
        check("t1_release_pr1", pr1, 1'b0);

        // 2: bounce 1,0,1,1,0 then held; final 0->1 first sampled at edge 6
        begin
            logic [4:0] bounce;
            bounce = 5'b01101;
            for (int i = 0; i < 5; i++) begin
                raw1 = bounce[i];
                tick(1);
            end
        end
        raw1 = 1'b1;
        tick(6);
        check("t2_sw1_edge11", sw1, 1'b0);
        check("t2_pr1_edge11", pr1, 1'b0);
        tick(1);
        check("t2_sw1_edge12", sw1, 1'b1);
        check("t2_pr1_edge12", pr1, 1'b1);
        raw1 = 1'b0;
        tick(7);
        check("t2_release_sw1", sw1, 1'b0);

        // 3: both channels together
        raw1 = 1'b1;
        raw2 = 1'b1;
        tick(6);
        check("t3_sw1_early", sw1, 1'b0);
        check("t3_sw2_early", sw2, 1'b0);
        tick(1);
        check("t3_sw1", sw1, 1'b1);
        check("t3_sw2", sw2, 1'b1);
        check("t3_pr1", pr1, 1'b1);
        check("t3_pr2", pr2, 1'b1);
        raw1 = 1'b0;
        raw2 = 1'b0;
        tick(7);
        check("t3_release_sw1", sw1, 1'b0);
        check("t3_release_sw2", sw2, 1'b0);

        // 4: disabled, then a full wait after re-enable
        en = 1'b0;
        raw2 = 1'b1;
        tick(20);
        check("t4_frozen_sw2", sw2, 1'b0);
        check("t4_frozen_pr2", pr2, 1'b0);
        en = 1'b1;
        tick(4);
        check("t4_en_edge4_sw2", sw2, 1'b0);
        tick(1);
        check("t4_en_edge5_sw2", sw2, 1'b1);
        check("t4_en_edge5_pr2", pr2, 1'b1);
        check("t4_sw1_idle", sw1, 1'b0);

        // 5: async reset mid-wait (cnt=3 after edge 5)
        raw1 = 1'b1;
        tick(5);
        check("t5_pre_reset_sw2", sw2, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_reset_sw1", sw1, 1'b0);
        check("t5_reset_sw2", sw2, 1'b0);
        tick(2);
        raw2 = 1'b0;
        rst_n = 1'b1;
        tick(6);
        check("t5_post_edge6_sw1", sw1, 1'b0);
        tick(1);
        check("t5_post_edge7_sw1", sw1, 1'b1);
        check("t5_post_edge7_pr1", pr1, 1'b1);
        check("t5_sw2", sw2, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
